// File: rtl/bsg_manycore_vcache_wh_to_dma.sv
// Memory-side wormhole endpoint for the vcache DMA network: turns incoming request
// packets into DMA requests/write data and returns in-order read fills as packets.
module bsg_manycore_vcache_wh_to_dma #(
    parameter int unsigned vcache_addr_width_p = 32,
    parameter int unsigned wh_flit_width_p     = 32,
    parameter int unsigned wh_cord_width_p     = 4,
    parameter int unsigned wh_len_width_p      = 4,
    parameter int unsigned wh_cid_width_p      = 2,
    parameter int unsigned block_flits_p       = 2,
    parameter int unsigned rd_fifo_els_p       = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [wh_flit_width_p+1:0]     wh_link_sif_i,
    output logic [wh_flit_width_p+1:0]     wh_link_sif_o,
    output logic [vcache_addr_width_p:0]   dma_pkt_o,
    output logic                           dma_pkt_v_o,
    input  logic                           dma_pkt_yumi_i,
    output logic [wh_flit_width_p-1:0]     dma_data_o,
    output logic                           dma_data_v_o,
    input  logic                           dma_data_yumi_i,
    input  logic [wh_flit_width_p-1:0]     dma_data_i,
    input  logic                           dma_data_v_i,
    output logic                           dma_data_yumi_o
);

    localparam int unsigned fw      = wh_flit_width_p;
    localparam int unsigned aw      = vcache_addr_width_p;
    localparam int unsigned cw      = wh_cord_width_p;
    localparam int unsigned lw      = wh_len_width_p;
    localparam int unsigned dw      = wh_cid_width_p;
    localparam int unsigned n       = block_flits_p;
    localparam int unsigned cnt_w   = $clog2(n + 1);
    localparam int unsigned ent_w   = cw + dw;
    localparam int unsigned ptr_w   = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
    localparam int unsigned occ_w   = $clog2(rd_fifo_els_p + 1);
    localparam int unsigned len_lsb = cw;
    localparam int unsigned src_lsb = cw + lw;
    localparam int unsigned cid_lsb = 2 * cw + lw;
    localparam int unsigned wnr_bit = 2 * cw + lw + dw;
    localparam int unsigned hdr_w   = wnr_bit + 1;

    typedef enum logic [1:0] {RX_HDR, RX_ADDR, RX_REQ, RX_DATA} rx_state_e;
    typedef enum logic       {TX_HDR, TX_DATA} tx_state_e;

    // link unpacking: {v, ready_and, data}
    logic          in_v;
    logic          out_ready;
    logic [fw-1:0] in_data;
    logic          in_ready;
    logic          out_v;
    logic [fw-1:0] out_data;

    assign in_v          = wh_link_sif_i[fw+1];
    assign out_ready     = wh_link_sif_i[fw];
    assign in_data       = wh_link_sif_i[fw-1:0];
    assign wh_link_sif_o = {out_v, in_ready, out_data};

    rx_state_e      rx_state;
    logic           wnr_r;
    logic [cw-1:0]  src_r;
    logic [dw-1:0]  cid_r;
    logic [aw-1:0]  addr_r;
    logic [cnt_w-1:0] rx_cnt;

    tx_state_e      tx_state;
    logic [cnt_w-1:0] tx_cnt;

    logic [ent_w-1:0] fifo_mem [rd_fifo_els_p];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [occ_w-1:0] occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rx_beat;
    logic             tx_beat;
    logic [ent_w-1:0] head;
    logic [hdr_w-1:0] hdr_bits;

    assign full  = (occ == occ_w'(rd_fifo_els_p));
    assign empty = (occ == '0);

    // RX side outputs
    assign dma_pkt_v_o  = (rx_state == RX_REQ) && (wnr_r || !full);
    assign dma_pkt_o    = {wnr_r, addr_r};
    assign dma_data_v_o = (rx_state == RX_DATA) && in_v;
    assign dma_data_o   = in_data;
    assign in_ready     = reset_n_i && ((rx_state == RX_HDR) || (rx_state == RX_ADDR)
                                        || ((rx_state == RX_DATA) && dma_data_yumi_i));
    assign rx_beat      = dma_data_v_o && dma_data_yumi_i;
    assign push         = (rx_state == RX_REQ) && !wnr_r && dma_pkt_yumi_i && !full;

    // TX side outputs; the header is built straight from the FIFO head
    assign head     = fifo_mem[rd_ptr];
    assign hdr_bits = {1'b0, head[cw +: dw], {cw{1'b0}}, lw'(n), head[cw-1:0]};
    assign out_v    = (tx_state == TX_HDR) ? !empty : dma_data_v_i;
    assign out_data = (tx_state == TX_HDR) ? fw'(hdr_bits) : dma_data_i;
    assign dma_data_yumi_o = (tx_state == TX_DATA) && dma_data_v_i && out_ready;
    assign tx_beat  = dma_data_yumi_o;
    assign pop      = tx_beat && (tx_cnt == cnt_w'(n - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state <= RX_HDR;
            wnr_r    <= 1'b0;
            src_r    <= '0;
            cid_r    <= '0;
            addr_r   <= '0;
            rx_cnt   <= '0;
        end else begin
            case (rx_state)
                RX_HDR: if (in_v) begin
                    wnr_r    <= in_data[wnr_bit];
                    src_r    <= in_data[src_lsb +: cw];
                    cid_r    <= in_data[cid_lsb +: dw];
                    rx_state <= RX_ADDR;
                end
                RX_ADDR: if (in_v) begin
                    addr_r   <= aw'(in_data);
                    rx_state <= RX_REQ;
                end
                RX_REQ: if (dma_pkt_yumi_i && dma_pkt_v_o) begin
                    rx_state <= wnr_r ? RX_DATA : RX_HDR;
                end
                RX_DATA: if (rx_beat) begin
                    if (rx_cnt == cnt_w'(n - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_HDR;
                    end else begin
                        rx_cnt <= rx_cnt + cnt_w'(1);
                    end
                end
                default: rx_state <= RX_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state <= TX_HDR;
            tx_cnt   <= '0;
        end else begin
            case (tx_state)
                TX_HDR: if (!empty && out_ready) tx_state <= TX_DATA;
                TX_DATA: if (tx_beat) begin
                    if (pop) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_HDR;
                    end else begin
                        tx_cnt <= tx_cnt + cnt_w'(1);
                    end
                end
                default: tx_state <= TX_HDR;
            endcase
        end
    end

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(rd_fifo_els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // read-tracking FIFO: pointers/occupancy reset, storage does not need to
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + occ_w'(1);
                2'b01:   occ <= occ - occ_w'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= {cid_r, src_r};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if ((rx_state == RX_HDR) && in_v) begin
                assert (in_data[wnr_bit] ? (in_data[len_lsb +: lw] == lw'(n + 1))
                                         : (in_data[len_lsb +: lw] == lw'(1)))
                    else $error("wh_to_dma: header len does not match request type");
            end
            assert (!(dma_data_v_i && empty))
                else $error("wh_to_dma: read data with no outstanding read");
        end
    end
`endif

endmodule
